// File: rtl/ps2_direction_decoder.sv
//------------------------------------------------------------------------------
// Module   : ps2_direction_decoder
// Purpose  : Turns PS/2 scan-code bytes (E0/F0 prefixed) into held-key levels.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_direction_decoder #(
   parameter int ACCEPT_KEYPAD  = 1,
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter int TO_W           = 22
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] ps2_key_data,
   input  logic       ps2_key_pressed,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic       key_w,
   output logic       key_s,
   output logic       event_valid,
   output logic [7:0] event_code,
   output logic       event_break,
   output logic       event_ext
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] c_to_one  = TO_W'(1);

   // Key bit order: {key_s, key_w, right, left, down, up}
   state_t          r_state;
   state_t          w_state_next;
   logic [TO_W-1:0] r_cnt;
   logic [TO_W-1:0] w_cnt_next;
   logic            r_strobe_d;
   logic [5:0]      r_keys;
   logic [5:0]      w_keys_next;
   logic            r_ev_valid;
   logic [7:0]      r_ev_code;
   logic            r_ev_break;
   logic            r_ev_ext;

   logic            w_accept;
   logic [5:0]      w_arrow_mask;
   logic [5:0]      w_kp_mask;
   logic [5:0]      w_plain_mask;
   logic [5:0]      w_mask;
   logic            w_is_break;
   logic            w_is_ext;
   logic            w_event;

   assign w_accept = ps2_key_pressed & ~r_strobe_d;

   always_comb begin
      w_arrow_mask = 6'b000000;
      case (ps2_key_data)
         8'h75:   w_arrow_mask = 6'b000001;
         8'h72:   w_arrow_mask = 6'b000010;
         8'h6B:   w_arrow_mask = 6'b000100;
         8'h74:   w_arrow_mask = 6'b001000;
         default: w_arrow_mask = 6'b000000;
      endcase
   end

   generate
      if (ACCEPT_KEYPAD != 0) begin : g_keypad
         assign w_kp_mask = w_arrow_mask;
      end else begin : g_no_keypad
         assign w_kp_mask = 6'b000000;
      end
   endgenerate

   always_comb begin
      w_plain_mask = w_kp_mask;
      if (ps2_key_data == 8'h1D) w_plain_mask = 6'b010000;
      if (ps2_key_data == 8'h1B) w_plain_mask = 6'b100000;
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_mask       = 6'b000000;
      w_is_break   = 1'b0;
      w_is_ext     = 1'b0;
      if (w_accept) begin
         // An accepted byte always beats a coincident timeout.
         w_cnt_next = '0;
         case (r_state)
            S_IDLE: begin
               if (ps2_key_data == 8'hE0)      w_state_next = S_EXT;
               else if (ps2_key_data == 8'hF0) w_state_next = S_BRK;
               else if (ps2_key_data != 8'hE1) w_mask = w_plain_mask;
            end
            S_EXT: begin
               if (ps2_key_data == 8'hF0)      w_state_next = S_EXT_BRK;
               else if (ps2_key_data == 8'hE0) w_state_next = S_EXT;
               else begin
                  w_mask       = w_arrow_mask;
                  w_is_ext     = 1'b1;
                  w_state_next = S_IDLE;
               end
            end
            S_BRK: begin
               w_mask       = w_plain_mask;
               w_is_break   = 1'b1;
               w_state_next = S_IDLE;
            end
            default: begin
               w_mask       = w_arrow_mask;
               w_is_break   = 1'b1;
               w_is_ext     = 1'b1;
               w_state_next = S_IDLE;
            end
         endcase
      end else if (r_state != S_IDLE) begin
         if (r_cnt == c_to_last) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end else begin
            w_cnt_next = r_cnt + c_to_one;
         end
      end else begin
         w_cnt_next = '0;
      end
   end

   // Only a real level change of a tracked key counts as an event.
   assign w_event     = w_is_break ? |(w_mask & r_keys) : |(w_mask & ~r_keys);
   assign w_keys_next = w_is_break ? (r_keys & ~w_mask) : (r_keys | w_mask);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_strobe_d <= 1'b0;
         r_keys     <= 6'b000000;
         r_ev_valid <= 1'b0;
         r_ev_code  <= 8'h00;
         r_ev_break <= 1'b0;
         r_ev_ext   <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_strobe_d <= ps2_key_pressed;
         r_keys     <= w_keys_next;
         r_ev_valid <= w_event;
         if (w_event) begin
            r_ev_code  <= ps2_key_data;
            r_ev_break <= w_is_break;
            r_ev_ext   <= w_is_ext;
         end
      end
   end

   assign up          = r_keys[0];
   assign down        = r_keys[1];
   assign left        = r_keys[2];
   assign right       = r_keys[3];
   assign key_w       = r_keys[4];
   assign key_s       = r_keys[5];
   assign event_valid = r_ev_valid;
   assign event_code  = r_ev_code;
   assign event_break = r_ev_break;
   assign event_ext   = r_ev_ext;

endmodule

`default_nettype wire

// File: tb/tb_ps2_direction_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_ps2_direction_decoder
// Purpose  : Directed self-checking bench, keypad-enabled and keypad-disabled DUTs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_direction_decoder;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] ps2_key_data = 8'h00;
   logic       ps2_key_pressed = 1'b0;

   logic       up_k, down_k, left_k, right_k, w_k, s_k, ev_k, brk_k, ext_k;
   logic [7:0] code_k;
   logic       up_n, down_n, left_n, right_n, w_n, s_n, ev_n, brk_n, ext_n;
   logic [7:0] code_n;
   logic [5:0] keys_k, keys_n;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   // Bit order {up, down, left, right, key_w, key_s}
   assign keys_k = {up_k, down_k, left_k, right_k, w_k, s_k};
   assign keys_n = {up_n, down_n, left_n, right_n, w_n, s_n};

   ps2_direction_decoder #(.ACCEPT_KEYPAD(1), .TIMEOUT_CYCLES(16), .TO_W(5)) dut_kp (
      .clock(clock), .resetn(resetn), .ps2_key_data(ps2_key_data),
      .ps2_key_pressed(ps2_key_pressed), .up(up_k), .down(down_k), .left(left_k),
      .right(right_k), .key_w(w_k), .key_s(s_k), .event_valid(ev_k),
      .event_code(code_k), .event_break(brk_k), .event_ext(ext_k));

   ps2_direction_decoder #(.ACCEPT_KEYPAD(0), .TIMEOUT_CYCLES(16), .TO_W(5)) dut_nk (
      .clock(clock), .resetn(resetn), .ps2_key_data(ps2_key_data),
      .ps2_key_pressed(ps2_key_pressed), .up(up_n), .down(down_n), .left(left_n),
      .right(right_n), .key_w(w_n), .key_s(s_n), .event_valid(ev_n),
      .event_code(code_n), .event_break(brk_n), .event_ext(ext_n));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [5:0] ek, input logic [5:0] en,
                            input logic evk, input logic evn);
      chk({tag, " keys_kp"}, 32'(keys_k), 32'(ek));
      chk({tag, " keys_nk"}, 32'(keys_n), 32'(en));
      chk({tag, " ev_kp"},   32'(ev_k),   32'(evk));
      chk({tag, " ev_nk"},   32'(ev_n),   32'(evn));
   endtask

   task automatic chk_evk(input string tag, input logic [7:0] code, input logic brk, input logic ext);
      chk({tag, " code_kp"}, 32'(code_k), 32'(code));
      chk({tag, " brk_kp"},  32'(brk_k),  32'(brk));
      chk({tag, " ext_kp"},  32'(ext_k),  32'(ext));
   endtask

   // Strobe high for n cycles; returns at the negedge just after the accepting edge.
   task automatic send_hold(input logic [7:0] b, input int n);
      @(negedge clock);
      ps2_key_data    = b;
      ps2_key_pressed = 1'b1;
      @(negedge clock);
      if (n > 1) repeat (n - 1) @(negedge clock);
      ps2_key_pressed = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      send_hold(b, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      // Reset
      idle(3);
      chk_state("reset", 6'b000000, 6'b000000, 1'b0, 1'b0);
      chk("reset code", 32'(code_k), 32'h0);
      resetn = 1'b1;
      idle(2);

      // Extended up press/release
      send(8'hE0);
      chk_state("E0 prefix", 6'b000000, 6'b000000, 1'b0, 1'b0);
      send(8'h75);
      chk_state("up make", 6'b100000, 6'b100000, 1'b1, 1'b1);
      chk_evk("up make", 8'h75, 1'b0, 1'b1);
      idle(1);
      chk_state("up make pulse end", 6'b100000, 6'b100000, 1'b0, 1'b0);
      send(8'hE0); send(8'hF0); send(8'h75);
      chk_state("up break", 6'b000000, 6'b000000, 1'b1, 1'b1);
      chk_evk("up break", 8'h75, 1'b1, 1'b1);

      // W and S
      send(8'h1D);
      chk_state("w make", 6'b000010, 6'b000010, 1'b1, 1'b1);
      send(8'h1B);
      chk_state("s make", 6'b000011, 6'b000011, 1'b1, 1'b1);
      send(8'hF0);
      chk_state("F0 prefix", 6'b000011, 6'b000011, 1'b0, 1'b0);
      send(8'h1D);
      chk_state("w break", 6'b000001, 6'b000001, 1'b1, 1'b1);
      chk_evk("w break", 8'h1D, 1'b1, 1'b0);

      // Typematic repeat of extended down
      for (int i = 0; i < 5; i++) begin
         send(8'hE0);
         send(8'h72);
         chk_state($sformatf("down repeat %0d", i), 6'b010001, 6'b010001, (i == 0), (i == 0));
      end

      // F0 strobe held 4 cycles must decode once, so 1B is a release
      send_hold(8'hF0, 4);
      send(8'h1B);
      chk_state("held strobe s break", 6'b010000, 6'b010000, 1'b1, 1'b1);
      chk_evk("held strobe s break", 8'h1B, 1'b1, 1'b0);
      send(8'hE0); send(8'hF0); send(8'h72);
      chk_state("down break", 6'b000000, 6'b000000, 1'b1, 1'b1);

      // Keypad 4
      send(8'h6B);
      chk_state("keypad left", 6'b001000, 6'b000000, 1'b1, 1'b0);
      chk_evk("keypad left", 8'h6B, 1'b0, 1'b0);
      send(8'hF0); send(8'h6B);
      chk_state("keypad left break", 6'b000000, 6'b000000, 1'b1, 1'b0);

      // Timeout: byte one cycle after the timeout edge is decoded from IDLE
      send(8'hE0);
      idle(15);
      send(8'h74);
      chk_state("after timeout 74", 6'b000100, 6'b000000, 1'b1, 1'b0);
      chk_evk("after timeout 74", 8'h74, 1'b0, 1'b0);
      send(8'hF0); send(8'h74);
      chk_state("keypad right break", 6'b000000, 6'b000000, 1'b1, 1'b0);

      // Byte on the exact timeout edge is still extended
      send(8'hE0);
      idle(14);
      send(8'h74);
      chk_state("timeout edge 74", 6'b000100, 6'b000100, 1'b1, 1'b1);
      chk_evk("timeout edge 74", 8'h74, 1'b0, 1'b1);
      send(8'hE0); send(8'hF0); send(8'h74);
      chk_state("right break", 6'b000000, 6'b000000, 1'b1, 1'b1);

      // Asynchronous reset mid-sequence
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'h6B);
      chk_state("up+left held", 6'b101000, 6'b101000, 1'b1, 1'b1);
      send(8'hE0);
      @(posedge clock);
      #2 resetn = 1'b0;
      #1;
      chk_state("async reset", 6'b000000, 6'b000000, 1'b0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      send(8'h6B);
      chk_state("post reset 6B", 6'b001000, 6'b000000, 1'b1, 1'b0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/ps2_direction_decoder.md
Name: ps2_direction_decoder

Overview:
- Converts the raw PS/2 scan-code byte stream from the keyboard interface into held-key level signals: up, down, left, right for paddle 1, and w, s for paddle 2.
- Sits between PS2_Interface (ps2_key_data / ps2_key_pressed) and vga_controller (up/down/left/right inputs).
- Tracks E0 (extended) and F0 (break) prefixes, so each output is high exactly while its key is physically held.

Parameters:
- ACCEPT_KEYPAD, 1: when 1, the non-extended codes 75/72/6B/74 (keypad 8/2/4/6) also drive up/down/left/right.
- TIMEOUT_CYCLES, 2500000: maximum clock cycles allowed between a prefix byte and its follow-up byte (50 ms at 50 MHz).
- TO_W, 22: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  input  1  system clock (50 MHz).
- resetn  input  1  asynchronous active-low reset.
- ps2_key_data  input  8  last received scan-code byte; valid while ps2_key_pressed is high.
- ps2_key_pressed  input  1  byte-received strobe from the keyboard interface.
- up  output  1  up arrow held (E0 75).
- down  output  1  down arrow held (E0 72).
- left  output  1  left arrow held (E0 6B).
- right  output  1  right arrow held (E0 74).
- key_w  output  1  W held (1D).
- key_s  output  1  S held (1B).
- event_valid  output  1  one-cycle pulse when a tracked key changes state.
- event_code  output  8  scan code of the last event, without prefixes.
- event_break  output  1  1 = release, 0 = press, for the last event.
- event_ext  output  1  1 if the last event was E0-prefixed.

Behaviour:
- Reset (resetn low, asynchronous): all outputs 0, state IDLE, timeout counter 0, strobe-history register 0. Reset asserted mid-sequence discards any pending prefix.
- Byte acceptance: a byte is accepted at a clock edge where ps2_key_pressed = 1 and its registered previous value = 0 (rising edge). A strobe held high for several cycles counts as one byte. ps2_key_data is sampled at the accepting edge.
- State machine (2-bit): IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> IDLE, ignored; any other byte is a make code -> set the matching non-extended key, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; other byte -> set the matching extended key -> IDLE.
  - BRK: any byte -> clear the matching non-extended key -> IDLE. E0 or F0 here is treated as an unmatched code.
  - EXT_BRK: any byte -> clear the matching extended key -> IDLE.
- Non-extended key map: 1D = key_w, 1B = key_s.
  - If ACCEPT_KEYPAD = 1, also 75 = up, 72 = down, 6B = left, 74 = right.
  - If ACCEPT_KEYPAD = 0, these four codes are ignored when non-extended.
- Extended key map: 75 / 72 / 6B / 74 map to up / down / left / right. Any other extended code is ignored; the FSM still returns to IDLE.
- Typematic repeat: a repeated make of an already-held key leaves the output at 1 and produces no event_valid pulse. A release of an already-released key leaves the output at 0 and produces no pulse.
- Latency: a key output and the event_* registers update at the accepting edge and are visible in the following cycle. event_valid is high for exactly that one cycle. event_code, event_break and event_ext hold their values until the next event.
- Timeout: the counter clears on every accepted byte and increments each cycle while state ≠ IDLE.
  - On reaching TIMEOUT_CYCLES - 1, state -> IDLE and the counter clears; key outputs are unchanged.
  - If a byte is accepted on the same edge as the timeout, the byte wins: it is decoded in the current state and the timeout is ignored.
  - The counter does not wrap while in IDLE; it is held at 0.
- Simultaneous keys: outputs are independent. up and down may both be 1; resolving conflicts is the consumer's job.
- No back-pressure: the decoder accepts one byte per strobe edge, with no buffering.

Test Plan:
- Reset, then bytes E0, 75 -> up = 1 after the second strobe, with event_valid pulse, event_code = 75, event_ext = 1, event_break = 0. Then E0, F0, 75 -> up = 0, event_break = 1.
- Bytes 1D, 1B, then F0, 1D -> key_w goes 1 then 0; key_s stays 1; up, down, left and right stay 0 throughout.
- Extended make 72 repeated 5 times (E0 72 each time) -> down = 1, exactly one event_valid pulse. Also hold ps2_key_pressed high for 4 cycles on a single byte -> decoded once.
- ACCEPT_KEYPAD = 1: byte 6B -> left = 1, event_ext = 0. ACCEPT_KEYPAD = 0: byte 6B -> left stays 0, no event_valid.
- Byte E0, then no strobe for TIMEOUT_CYCLES (use TIMEOUT_CYCLES = 16 in simulation), then byte 74 -> right stays 0 (74 is decoded as a non-extended keypad 6 -> right = 1 only when ACCEPT_KEYPAD = 1). Also: byte arriving on the exact timeout edge is decoded as extended.
- Hold up and left, pulse resetn low for 1 cycle mid-way through E0 F0 -> all outputs 0 immediately. Next byte 6B with ACCEPT_KEYPAD = 0 is treated from IDLE -> no change.
